// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared register-address default and hazard cause encoding for hazard_scoreboard
package hazard_pkg;
  localparam int REG_AW_DEF = 5;
  typedef enum logic [2:0] {NONE, LOAD_USE, RAW_MD, WAW_MD, STRUCT_MD, BRANCH} hz_cause_t;
endpackage

// File: rtl/hazard_scoreboard_md_scoreboard.sv
// md_scoreboard: pending-register bits, outstanding count and sticky error for mul/div ops (in: issue/issue_rd, done/done_rd; out: pending, count, err)
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue,
  input  logic [REG_AW-1:0]                  issue_rd,
  input  logic                               done,
  input  logic [REG_AW-1:0]                  done_rd,
  output logic [2**REG_AW-1:0]               pending,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  count,
  output logic                               err
);
  localparam int NR = 2**REG_AW;
  localparam int CW = $clog2(MAX_INFLIGHT+1);
  localparam logic [NR-1:0] ONE = NR'(1);
  logic [NR-1:0] pending_q, pending_d, clr, set;
  logic [CW-1:0] count_q, count_d;
  logic err_q, err_d, done_ok;
  always_comb begin
    done_ok = done && count_q != '0;
    clr = done_ok ? ONE << done_rd : '0;
    set = issue && issue_rd != '0 ? ONE << issue_rd : '0;
    pending_d = (pending_q & ~clr) | set;
    count_d = count_q + CW'(issue) - CW'(done_ok);
    err_d = err_q || (done && count_q == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
  assign pending = pending_q;
  assign count = count_q;
  assign err = err_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID/EX stall/flush controller with mul/div scoreboard (in: ID/EX fields, branch, md_done; out: stall, pc_write, if_id_write, flushes, sb_pending, inflight_cnt, stall_cycles, sb_err)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W = 32,
  parameter bit DONE_BYPASS = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  input  logic [REG_AW-1:0]                  id_rs1,
  input  logic [REG_AW-1:0]                  id_rs2,
  input  logic                               id_uses_rs1,
  input  logic                               id_uses_rs2,
  input  logic [REG_AW-1:0]                  id_rd,
  input  logic                               id_regwrite,
  input  logic                               id_is_muldiv,
  input  logic [REG_AW-1:0]                  ex_rd,
  input  logic                               ex_memread,
  input  logic                               ex_branch_taken,
  input  logic                               md_done,
  input  logic [REG_AW-1:0]                  md_done_rd,
  output logic                               stall,
  output logic                               pc_write,
  output logic                               if_id_write,
  output logic                               if_id_flush,
  output logic                               id_ex_flush,
  output logic [2**REG_AW-1:0]               sb_pending,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_cnt,
  output logic [CNT_W-1:0]                   stall_cycles,
  output logic                               sb_err
);
  localparam int CW = $clog2(MAX_INFLIGHT+1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);
  hz_cause_t cause;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic byp1, byp2, bypd, load_use, raw_md, waw_md, struct_md, issue;
  always_comb begin
    byp1 = DONE_BYPASS && md_done && md_done_rd == id_rs1;
    byp2 = DONE_BYPASS && md_done && md_done_rd == id_rs2;
    bypd = DONE_BYPASS && md_done && md_done_rd == id_rd;
    load_use = ex_memread && ex_rd != '0 &&
               ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    raw_md = (id_uses_rs1 && id_rs1 != '0 && sb_pending[id_rs1] && !byp1) ||
             (id_uses_rs2 && id_rs2 != '0 && sb_pending[id_rs2] && !byp2);
    waw_md = id_regwrite && id_rd != '0 && sb_pending[id_rd] && !bypd;
    struct_md = id_is_muldiv && inflight_cnt == MAX_C && !md_done;
    cause = rst ? NONE : ex_branch_taken ? BRANCH : !id_valid ? NONE :
            load_use ? LOAD_USE : raw_md ? RAW_MD : waw_md ? WAW_MD :
            struct_md ? STRUCT_MD : NONE;
    stall = cause != NONE && cause != BRANCH;
    pc_write = !stall;
    if_id_write = !stall;
    if_id_flush = cause == BRANCH;
    id_ex_flush = stall || cause == BRANCH;
    issue = id_valid && id_is_muldiv && !stall && !ex_branch_taken;
    stall_cycles_d = stall && !(&stall_cycles_q) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else stall_cycles_q <= stall_cycles_d;
  end
  assign stall_cycles = stall_cycles_q;
  md_scoreboard #(.REG_AW(REG_AW), .MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .issue   (issue),
    .issue_rd(id_rd),
    .done    (md_done),
    .done_rd (md_done_rd),
    .pending (sb_pending),
    .count   (inflight_cnt),
    .err     (sb_err)
  );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: vector table, directed corner sequences and random stimulus against a register-level reference model
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_is_muldiv;
  logic ex_memread, ex_branch_taken, md_done;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, md_done_rd;
  logic stall, pc_write, if_id_write, if_id_flush, id_ex_flush, sb_err;
  logic [31:0] sb_pending, stall_cycles;
  logic [1:0] inflight_cnt;
  logic b_stall, b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_sb_err;
  logic [31:0] b_sb_pending;
  logic [1:0] b_inflight_cnt;
  logic [2:0] b_stall_cycles;
  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_muldiv(id_is_muldiv), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .md_done(md_done),
    .md_done_rd(md_done_rd), .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .sb_pending(sb_pending),
    .inflight_cnt(inflight_cnt), .stall_cycles(stall_cycles), .sb_err(sb_err)
  );
  hazard_scoreboard #(.CNT_W(3), .DONE_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_muldiv(id_is_muldiv), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .md_done(md_done),
    .md_done_rd(md_done_rd), .stall(b_stall), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .sb_pending(b_sb_pending),
    .inflight_cnt(b_inflight_cnt), .stall_cycles(b_stall_cycles), .sb_err(b_sb_err)
  );
  int n_cmp = 0;
  int n_bad = 0;
  bit pend_m[32];
  int cnt_m = 0;
  bit err_m = 0;
  longint stalls_m = 0;
  typedef struct {
    logic v, u1, u2, mr, br;
    logic [4:0] rs1, rs2, exrd;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic bit byp(logic [4:0] r);
    return md_done && md_done_rd == r;
  endfunction
  function automatic bit exp_stall();
    bit lu, raw, waw, st;
    if (rst || ex_branch_taken || !id_valid) return 1'b0;
    lu = ex_memread && ex_rd != 0 &&
         ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    raw = (id_uses_rs1 && id_rs1 != 0 && pend_m[id_rs1] && !byp(id_rs1)) ||
          (id_uses_rs2 && id_rs2 != 0 && pend_m[id_rs2] && !byp(id_rs2));
    waw = id_regwrite && id_rd != 0 && pend_m[id_rd] && !byp(id_rd);
    st = id_is_muldiv && cnt_m == 2 && !md_done;
    return lu || raw || waw || st;
  endfunction
  function automatic logic [31:0] pend_vec();
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[i] = pend_m[i];
    return p;
  endfunction
  task automatic check_comb(string tag);
    bit s, br;
    s = exp_stall();
    br = !rst && ex_branch_taken;
    chk({tag, ".stall"}, stall, s);
    chk({tag, ".pc_write"}, pc_write, !s);
    chk({tag, ".if_id_write"}, if_id_write, !s);
    chk({tag, ".if_id_flush"}, if_id_flush, br);
    chk({tag, ".id_ex_flush"}, id_ex_flush, br || s);
  endtask
  task automatic clk_step(string tag);
    bit s, iss, errev;
    s = exp_stall();
    if (rst) begin
      for (int i = 0; i < 32; i++) pend_m[i] = 0;
      cnt_m = 0;
      err_m = 0;
      stalls_m = 0;
    end else begin
      iss = id_valid && id_is_muldiv && !s && !ex_branch_taken;
      errev = md_done && cnt_m == 0;
      if (md_done && !errev) begin
        pend_m[md_done_rd] = 0;
        cnt_m--;
      end
      if (iss) begin
        if (id_rd != 0) pend_m[id_rd] = 1;
        cnt_m++;
      end
      if (errev) err_m = 1;
      if (s && stalls_m < 64'hFFFF_FFFF) stalls_m++;
    end
    @(posedge clk);
    #1;
    chk({tag, ".sb_pending"}, sb_pending, pend_vec());
    chk({tag, ".inflight_cnt"}, inflight_cnt, cnt_m);
    chk({tag, ".stall_cycles"}, stall_cycles, stalls_m);
    chk({tag, ".sb_err"}, sb_err, err_m);
    @(negedge clk);
  endtask
  task automatic cyc(string tag);
    #1;
    check_comb(tag);
    clk_step(tag);
  endtask
  task automatic idle();
    rst = 0; id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_regwrite = 0;
    id_is_muldiv = 0; ex_memread = 0; ex_branch_taken = 0; md_done = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_rd = 0; md_done_rd = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    cyc("reset");
    rst = 0;
  endtask
  task automatic muldiv(logic [4:0] rd);
    idle();
    id_valid = 1; id_is_muldiv = 1; id_regwrite = 1; id_rd = rd;
  endtask
  initial begin
    logic [63:0] s0, b0;
    idle();
    tbl[0] = '{1, 0, 1, 1, 0, 5'd0, 5'd5, 5'd5, 5'b10001};
    tbl[1] = '{1, 1, 0, 1, 0, 5'd5, 5'd0, 5'd5, 5'b10001};
    tbl[2] = '{1, 0, 0, 1, 0, 5'd5, 5'd5, 5'd5, 5'b01100};
    tbl[3] = '{1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 5'b01100};
    tbl[4] = '{1, 1, 0, 0, 0, 5'd5, 5'd0, 5'd5, 5'b01100};
    tbl[5] = '{0, 1, 0, 1, 0, 5'd5, 5'd0, 5'd5, 5'b01100};
    tbl[6] = '{1, 1, 0, 1, 1, 5'd5, 5'd0, 5'd5, 5'b01111};
    tbl[7] = '{0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 5'b01111};
    tbl[8] = '{1, 0, 1, 1, 0, 5'd5, 5'd6, 5'd5, 5'b01100};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle();
      id_valid = tbl[i].v; id_uses_rs1 = tbl[i].u1; id_uses_rs2 = tbl[i].u2;
      ex_memread = tbl[i].mr; ex_branch_taken = tbl[i].br;
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].exrd;
      #1;
      chk($sformatf("vec%0d", i), {stall, pc_write, if_id_write, if_id_flush, id_ex_flush}, tbl[i].exp);
      clk_step("vec");
    end
    do_reset();
    s0 = stall_cycles;
    idle(); id_valid = 1; ex_memread = 1; ex_rd = 5; id_uses_rs2 = 1; id_rs2 = 5;
    cyc("lu");
    ex_memread = 0;
    cyc("lu_next");
    chk("lu_stall_cycles", stall_cycles - s0, 1);
    do_reset();
    s0 = stall_cycles;
    b0 = b_stall_cycles;
    muldiv(7);
    cyc("raw_issue");
    idle(); id_valid = 1; id_uses_rs1 = 1; id_rs1 = 7; id_regwrite = 1; id_rd = 8;
    repeat (4) cyc("raw_wait");
    md_done = 1; md_done_rd = 7;
    cyc("raw_done");
    md_done = 0;
    cyc("raw_after");
    chk("raw_stalls_bypass", stall_cycles - s0, 4);
    chk("raw_stalls_nobypass", b_stall_cycles - b0, 5);
    chk("raw_bit7", sb_pending[7], 0);
    muldiv(3);
    cyc("st_issue3");
    muldiv(4);
    cyc("st_issue4");
    muldiv(5);
    repeat (3) cyc("st_wait");
    md_done = 1; md_done_rd = 3;
    cyc("st_swap");
    chk("st_cnt", inflight_cnt, 2);
    chk("st_pend", sb_pending[5:3], 3'b110);
    chk("nobypass_sat", b_stall_cycles, 7);
    idle(); md_done = 1; md_done_rd = 4;
    cyc("st_drain4");
    md_done_rd = 5;
    cyc("st_drain5");
    idle(); id_valid = 1; ex_memread = 1; ex_rd = 5; id_uses_rs2 = 1; id_rs2 = 5;
    id_is_muldiv = 1; id_regwrite = 1; id_rd = 9; ex_branch_taken = 1;
    #1;
    chk("br_outs", {stall, if_id_flush, id_ex_flush, pc_write, if_id_write}, 5'b01111);
    check_comb("br");
    clk_step("br");
    chk("br_pend9", sb_pending[9], 0);
    chk("br_cnt", inflight_cnt, 0);
    muldiv(0);
    cyc("x0_issue");
    chk("x0_pend", sb_pending, 0);
    chk("x0_cnt", inflight_cnt, 1);
    idle(); id_valid = 1; id_uses_rs1 = 1; id_rs1 = 0;
    #1;
    chk("x0_read_stall", stall, 0);
    clk_step("x0_read");
    idle(); md_done = 1; md_done_rd = 0;
    cyc("x0_done");
    idle(); md_done = 1; md_done_rd = 3;
    cyc("err_set");
    chk("err_set", sb_err, 1);
    idle();
    repeat (3) cyc("err_hold");
    chk("err_sticky", sb_err, 1);
    do_reset();
    chk("rst_state", {sb_pending, inflight_cnt, stall_cycles, sb_err}, 0);
    muldiv(6);
    cyc("mid_issue");
    do_reset();
    idle(); md_done = 1; md_done_rd = 6;
    cyc("post_rst_done");
    chk("post_rst_err", sb_err, 1);
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom % 64) == 0;
      id_valid = ($urandom % 4) != 0;
      id_rs1 = 5'($urandom % 8); id_rs2 = 5'($urandom % 8); id_rd = 5'($urandom % 8);
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); id_regwrite = 1'($urandom);
      id_is_muldiv = ($urandom % 3) == 0;
      ex_rd = 5'($urandom % 8);
      ex_memread = ($urandom % 4) == 0;
      ex_branch_taken = ($urandom % 10) == 0;
      md_done = cnt_m > 0 && ($urandom % 3) == 0;
      md_done_rd = 5'($urandom % 8);
      cyc("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and stall controller for the 5-stage pipeline that sits between ID and EX. It generalises load-use detection with a per-register scoreboard for up to `MAX_INFLIGHT` outstanding multi-cycle mul/div operations. It also adds RAW/WAW interlocks against those operations, taken-branch flush priority, a saturating stall-cycle counter and a sticky protocol-error flag.

## Interface
Parameters:
- `REG_AW`, default 5: register address width. `NUM_REGS` = 2**`REG_AW`.
- `MAX_INFLIGHT`, default 2: maximum outstanding mul/div ops (≥1).
- `CNT_W`, default 32: width of the stall-cycle counter.
- `DONE_BYPASS`, default 1: when 1, a register completing this cycle does not cause a stall.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in `REG_AW`: ID source registers.
- `id_uses_rs1`, `id_uses_rs2` in 1: the source is actually read.
- `id_rd` in `REG_AW`: ID destination register.
- `id_regwrite` in 1: the ID instruction writes `id_rd`.
- `id_is_muldiv` in 1: the ID instruction is a mul/div.
- `ex_rd` in `REG_AW`: EX destination register.
- `ex_memread` in 1: the EX instruction is a load.
- `ex_branch_taken` in 1: redirect resolved in EX.
- `md_done` in 1: mul/div result written back this cycle.
- `md_done_rd` in `REG_AW`: register of that result.
- `stall` out 1: ID is held this cycle.
- `pc_write` out 1: PC may update.
- `if_id_write` out 1: IF/ID may load.
- `if_id_flush` out 1: zero IF/ID.
- `id_ex_flush` out 1: insert a bubble into ID/EX.
- `sb_pending` out `NUM_REGS`: scoreboard bits.
- `inflight_cnt` out clog2(`MAX_INFLIGHT`+1): number of outstanding ops.
- `stall_cycles` out `CNT_W`: saturating count of stall cycles.
- `sb_err` out 1: sticky protocol error.

## Operation
Hazard terms, all combinational. x0 never hazards.
- **load_use:** `ex_memread` and `ex_rd`≠0 and (`ex_rd`==`id_rs1` with `id_uses_rs1`, or `ex_rd`==`id_rs2` with `id_uses_rs2`).
- **raw_md:** a used source register r≠0 has `sb_pending[r]`. Excluded when `DONE_BYPASS` and `md_done` and `md_done_rd`==r.
- **waw_md:** `id_regwrite` and `id_rd`≠0 and `sb_pending[id_rd]`. The `DONE_BYPASS` exclusion applies the same way.
- **struct_md:** `id_is_muldiv` and `inflight_cnt`==`MAX_INFLIGHT` and not `md_done`.
- `hz` = `id_valid` and any of the four terms above.

Output priority, highest first:
- **`ex_branch_taken`:** `if_id_flush`=1, `id_ex_flush`=1, `pc_write`=1, `if_id_write`=1, `stall`=0.
- **`hz`:** `stall`=1, `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `if_id_flush`=0.
- **Otherwise:** `stall`=0, `pc_write`=1, `if_id_write`=1, both flushes 0.

Issue and completion:
- **issue** = `id_valid` and `id_is_muldiv` and not `stall` and not `ex_branch_taken`.
- On issue, set `sb_pending[id_rd]` if `id_rd`≠0.
- On `md_done`, clear `sb_pending[md_done_rd]`.
- Issue and done on the same register in the same cycle: the bit ends up set.
- `inflight_cnt` changes by +1 on issue and −1 on `md_done`; it is unchanged when both occur.
- `md_done` with `inflight_cnt`==0 sets `sb_err`. In that case the count and scoreboard do not change.
- `stall_cycles` increments every cycle `stall`=1 and saturates at all-ones.

## Timing
- Hazard outputs are combinational in the current cycle. Scoreboard, count, error flag and counter update on the rising edge of `clk`.
- A load-use hazard produces exactly 1 stall cycle, because the load leaves EX on the next cycle.
- A mul/div RAW stall lasts until the cycle `md_done` names the register: with `DONE_BYPASS`=1 it ends in that cycle, with `DONE_BYPASS`=0 one cycle later.
- Reset clears `sb_pending`, `inflight_cnt`, `stall_cycles` and `sb_err` to 0. While `rst` is high, outputs are `stall`=0, `pc_write`=1, `if_id_write`=1, and both flushes 0.
- Asserting `rst` mid-operation discards every pending entry. A `md_done` arriving after reset therefore sets `sb_err`, and this is by design.

## Structure
- The shared package `hazard_pkg` holds the `REG_AW` default and the `hz_cause_t` enum (NONE, LOAD_USE, RAW_MD, WAW_MD, STRUCT_MD, BRANCH).
- `hz_cause_t` is exposed internally for debug.
- The scoreboard array, count and error logic form one sub-module, `md_scoreboard`. Its inputs are issue, issue_rd, done and done_rd; its outputs are pending, count and err.

## Test plan
- **Load-use:** `ex_memread`=1, `ex_rd`=5, `id_rs2`=5 used -> `stall`=1 and `id_ex_flush`=1 for exactly one cycle. `stall_cycles` goes 0→1.
- **Mul/div RAW:** issue mul/div with `id_rd`=7, then an ID instruction reads x7. Raise `md_done` on x7 four cycles later -> 4 stall cycles and bit 7 cleared. With `DONE_BYPASS`=0 the same stimulus gives 5 stall cycles.
- **Structural:** with `MAX_INFLIGHT`=2, issue to x3 and x4, then a third mul/div -> stalled until `md_done`. Same-cycle done and issue leaves `inflight_cnt`=2.
- **Branch priority:** load-use hazard plus `ex_branch_taken` -> `stall`=0, both flushes 1, no scoreboard set for the squashed mul/div.
- **Writes to x0:** mul/div to x0 -> `sb_pending` stays 0 and `inflight_cnt`=1. A later read of x0 does not stall.
- **Error and reset:** `md_done` with `inflight_cnt`=0 -> `sb_err`=1 and it stays 1. Then assert `rst` for 1 cycle -> all state is 0 and `sb_err`=0.
